// File: rtl/proteus_nbout_packer_if.sv
// Output-side bus for the NBout packer: input vector stream in, packed word beats out.
// The slave modport is the packer's view; the master modport is the neighbour driving
// i_valid/i_data and accepting beats with i_ready.
interface proteus_nbout_packer_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned TN = 16
);
    logic            i_valid;
    logic [N*TN-1:0] i_data;
    logic            o_ready;
    logic            o_valid;
    logic [N*TN-1:0] o_data;
    logic            i_ready;

    modport slave  (input  i_valid, i_data, i_ready, output o_ready, o_valid, o_data);
    modport master (output i_valid, i_data, i_ready, input  o_ready, o_valid, o_data);
endinterface

// File: rtl/proteus_nbout_packer.sv
// NBout packer: squeezes Tn lanes of 16-bit results into P-bit fields, LSB-first per lane,
// and emits whole N-bit words, one word per lane per beat, all lanes in lockstep.
// Optional feature macro: PACKER_SATURATE_EN (clamp to signed P-bit range before packing).
module proteus_nbout_packer #(
    parameter int unsigned N         = 16,
    parameter int unsigned TN        = 16,
    parameter int unsigned BIT_IDX   = 4,
    parameter int unsigned FILL_BITS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load_cfg,
    input  logic [BIT_IDX-1:0] i_p,
    input  logic               i_flush,
    output logic               o_flush_done,
    output logic               o_cfg_err,
    proteus_nbout_packer_if.slave bus
);
    localparam int unsigned BW = 2 * N;
    localparam int unsigned FW = FILL_BITS + 1;
    localparam int unsigned PW = BIT_IDX + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state;
    logic [BW-1:0]        lane_buf   [TN];
    logic [BW-1:0]        lane_buf_n [TN];
    logic [FILL_BITS-1:0] f_q;
    logic [FILL_BITS-1:0] f_pop;
    logic [FILL_BITS-1:0] f_n;
    logic [BIT_IDX-1:0]   p_q;
    logic [BIT_IDX-1:0]   p_nxt;
    logic                 valid_q;
    logic                 ready_q;
    logic                 pop;
    logic                 push;
    logic                 cfg_ok;
    logic                 room_n;
    logic [FW-1:0]        room_sum;

    // Reduce one 16-bit result to its P-bit field (bits above P are zero).
    function automatic logic [N-1:0] make_field(input logic [N-1:0] v, input logic [PW-1:0] pw);
        logic [N-1:0] mask;
`ifdef PACKER_SATURATE_EN
        logic signed [N:0] sv;
        logic signed [N:0] hi;
        logic signed [N:0] lo;
`endif
        mask = (pw >= PW'(N)) ? '1 : ((N'(1) << pw) - N'(1));
`ifdef PACKER_SATURATE_EN
        sv = $signed({v[N-1], v});
        hi = $signed({1'b0, (N'(1) << (pw - PW'(1))) - N'(1)});
        lo = ~hi;
        if (sv > hi) begin
            sv = hi;
        end else if (sv < lo) begin
            sv = lo;
        end
        return sv[N-1:0] & mask;
`else
        return v & mask;
`endif
    endfunction

    // Datapath next state: pop first, then insert the new field at the post-pop fill.
    always_comb begin
        pop  = valid_q & bus.i_ready;
        push = bus.i_valid & ready_q;
        if (!pop) begin
            f_pop = f_q;
        end else if ((state == FLUSH) && (f_q < FILL_BITS'(N))) begin
            f_pop = '0;
        end else begin
            f_pop = f_q - FILL_BITS'(N);
        end
        f_n = push ? (f_pop + FILL_BITS'(p_q) + FILL_BITS'(1)) : f_pop;
        for (int l = 0; l < TN; l++) begin
            lane_buf_n[l] = pop ? (lane_buf[l] >> N) : lane_buf[l];
            if (push) begin
                lane_buf_n[l] = lane_buf_n[l] |
                    ({N'(0), make_field(bus.i_data[l*N +: N], PW'(p_q) + PW'(1))} << f_pop);
            end
        end
        cfg_ok   = i_load_cfg && ((state == IDLE) ||
                   ((state == RUN) && (f_q == '0) && !bus.i_valid));
        p_nxt    = cfg_ok ? i_p : p_q;
        room_sum = FW'(f_n) + FW'(p_nxt) + FW'(1);
        room_n   = (room_sum <= FW'(BW));
    end

    // Control FSM plus buffer, fill and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            f_q          <= '0;
            p_q          <= '1;
            valid_q      <= 1'b0;
            ready_q      <= 1'b0;
            o_flush_done <= 1'b0;
            o_cfg_err    <= 1'b0;
            for (int l = 0; l < TN; l++) begin
                lane_buf[l] <= '0;
            end
        end else begin
            f_q          <= f_n;
            p_q          <= p_nxt;
            o_cfg_err    <= i_load_cfg && !cfg_ok;
            o_flush_done <= 1'b0;
            for (int l = 0; l < TN; l++) begin
                lane_buf[l] <= lane_buf_n[l];
            end
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    ready_q <= cfg_ok && room_n;
                    if (cfg_ok) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    valid_q <= (f_n >= FILL_BITS'(N)) || (i_flush && (f_n != '0));
                    ready_q <= !i_flush && room_n;
                    if (i_flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (f_q == '0) begin
                        state        <= RUN;
                        o_flush_done <= 1'b1;
                        valid_q      <= 1'b0;
                        ready_q      <= room_n;
                    end else begin
                        valid_q <= (f_n != '0);
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Beat data is the low word of each lane buffer.
    always_comb begin
        bus.o_valid = valid_q;
        bus.o_ready = ready_q;
        bus.o_data  = '0;
        for (int l = 0; l < TN; l++) begin
            bus.o_data[l*N +: N] = lane_buf[l][N-1:0];
        end
    end
endmodule

// File: tb/tb_proteus_nbout_packer.sv
// Scoreboard bench for proteus_nbout_packer: per-lane bit accumulator model feeds an
// expected-beat queue; an independent monitor compares every accepted beat.
module tb_proteus_nbout_packer;
    localparam int unsigned N  = 16;
    localparam int unsigned TN = 16;
    localparam int unsigned W  = N * TN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_load_cfg = 1'b0;
    logic [3:0] i_p = 4'd15;
    logic       i_flush = 1'b0;
    logic       o_flush_done;
    logic       o_cfg_err;

    proteus_nbout_packer_if #(.N(N), .TN(TN)) bus ();

    proteus_nbout_packer #(.N(N), .TN(TN), .BIT_IDX(4), .FILL_BITS(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_cfg   (i_load_cfg),
        .i_p          (i_p),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done),
        .o_cfg_err    (o_cfg_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int           mp = 16;
    int           nb = 0;
    logic [63:0]  acc [TN];
    logic [W-1:0] expq [$];
    int           rdy_mode = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    function automatic logic [15:0] fld(input logic [15:0] v, input int p);
        int sv;
        sv = int'($signed(v));
`ifdef PACKER_SATURATE_EN
        if (sv > (1 << (p - 1)) - 1) sv = (1 << (p - 1)) - 1;
        if (sv < -(1 << (p - 1)))    sv = -(1 << (p - 1));
`endif
        return 16'(sv & ((1 << p) - 1));
    endfunction

    function automatic logic [W-1:0] rand_vec(input logic [15:0] v0);
        logic [W-1:0] v;
        for (int l = 0; l < TN; l++) begin
            if ($urandom_range(0, 3) == 0) v[l*N +: N] = 16'(int'($urandom_range(0, 63)) - 32);
            else                           v[l*N +: N] = 16'($urandom);
        end
        v[15:0] = v0;
        return v;
    endfunction

    task automatic model_push(input logic [W-1:0] d);
        logic [W-1:0] beat;
        for (int l = 0; l < TN; l++) acc[l] = acc[l] | (64'(fld(d[l*N +: N], mp)) << nb);
        nb += mp;
        while (nb >= N) begin
            for (int l = 0; l < TN; l++) begin
                beat[l*N +: N] = acc[l][15:0];
                acc[l] = acc[l] >> N;
            end
            expq.push_back(beat);
            nb -= N;
        end
    endtask

    task automatic model_flush();
        logic [W-1:0] beat;
        if (nb > 0) begin
            for (int l = 0; l < TN; l++) begin
                beat[l*N +: N] = acc[l][15:0];
                acc[l] = '0;
            end
            expq.push_back(beat);
        end
        nb = 0;
    endtask

    task automatic model_clear();
        expq.delete();
        nb = 0;
        mp = 16;
        for (int l = 0; l < TN; l++) acc[l] = '0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_flush     = 1'b0;
        i_load_cfg  = 1'b0;
    endtask

    // Present d until accepted; optional flush on the accepting cycle.
    task automatic push(input logic [W-1:0] d, input bit fl);
        bit acc_ok;
        int k;
        acc_ok = 1'b0;
        k = 0;
        while (!acc_ok && k < 100) begin
            @(negedge clk);
            acc_ok      = bus.o_ready;
            bus.i_valid = 1'b1;
            bus.i_data  = d;
            i_load_cfg  = 1'b0;
            i_flush     = fl & acc_ok;
            k++;
        end
        if (acc_ok) begin
            model_push(d);
            if (fl) model_flush();
        end else begin
            chk("push_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic cfg(input int p);
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_flush     = 1'b0;
        i_load_cfg  = 1'b1;
        i_p         = 4'(p - 1);
        @(negedge clk);
        i_load_cfg = 1'b0;
        chk("cfg_no_err", o_cfg_err, 1'b0);
        mp = p;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            idle();
            done = o_flush_done;
        end
        chk("flush_done", done, 1'b1);
        chk("flush_to_run_ready", bus.o_ready, 1'b1);
        chk("flush_drained", W'(expq.size()), '0);
    endtask

    task automatic do_flush(input bit with_push, input logic [W-1:0] d);
        if (with_push) begin
            push(d, 1'b1);
        end else begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            i_flush     = 1'b1;
            model_flush();
        end
        wait_done();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        i_flush     = 1'b0;
        i_load_cfg  = 1'b0;
        @(negedge clk);
        model_clear();
        rst = 1'b0;
    endtask

    // downstream ready pattern
    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_ready = 1'b0;
                1:       bus.i_ready = 1'b1;
                default: bus.i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: compare each accepted beat, and check stability while stalled
    initial begin
        bit           stalled;
        logic [W-1:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", bus.o_valid, 1'b1);
                    chk("stall_data", bus.o_data, held);
                end
                if (bus.o_valid && bus.i_ready) begin
                    if (expq.size() == 0) begin
                        n_chk++;
                        $display("FAIL beat: unexpected beat %h, required none", bus.o_data);
                    end else begin
                        chk("beat", bus.o_data, expq.pop_front());
                    end
                end
                stalled = bus.o_valid && !bus.i_ready;
                held    = bus.o_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        int cnt;
        bit ok;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        model_clear();

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b0);
        chk("rst_data", bus.o_data, '0);
        chk("rst_flush_done", o_flush_done, 1'b0);
        chk("rst_cfg_err", o_cfg_err, 1'b0);

        // 1: passthrough at P=16, one-cycle latency
        cfg(16);
        rdy_mode = 1;
        push(rand_vec(16'h1234), 1'b0);
        idle();
        chk("t1_latency_a", bus.o_valid, 1'b1);
        chk("t1_word_a", bus.o_data[15:0], 16'h1234);
        push(rand_vec(16'hBEEF), 1'b0);
        idle();
        chk("t1_latency_b", bus.o_valid, 1'b1);
        chk("t1_word_b", bus.o_data[15:0], 16'hBEEF);
        do_flush(1'b0, '0);

        // 2: P=8, two pushes make one word
        cfg(8);
        push(rand_vec(16'h0012), 1'b0);
        idle();
        chk("t2_no_beat", bus.o_valid, 1'b0);
        push(rand_vec(16'h0034), 1'b0);
        idle();
        chk("t2_valid", bus.o_valid, 1'b1);
        chk("t2_word", bus.o_data[15:0], 16'h3412);
        do_flush(1'b0, '0);

        // 3: P=5 padded flush word
        cfg(5);
        push(rand_vec(16'd1), 1'b0);
        push(rand_vec(16'd2), 1'b0);
        push(rand_vec(16'd3), 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_flush     = 1'b1;
        model_flush();
        idle();
        chk("t3_pad_valid", bus.o_valid, 1'b1);
        chk("t3_pad_word", bus.o_data[15:0], 16'h0C41);
        wait_done();

        // 4: P=4 saturation vs truncation
        cfg(4);
        push(rand_vec(16'h0100), 1'b0);
        push(rand_vec(16'hFFF0), 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_flush     = 1'b1;
        model_flush();
        idle();
`ifdef PACKER_SATURATE_EN
        chk("t4_field", bus.o_data[15:0], 16'h0087);
`else
        chk("t4_field", bus.o_data[15:0], 16'h0000);
`endif
        wait_done();

        // 5: P=8 with downstream stalled: buffer fills after four accepts
        cfg(8);
        rdy_mode = 0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ok          = bus.o_ready;
            d           = rand_vec(16'($urandom));
            bus.i_valid = 1'b1;
            bus.i_data  = d;
            if (ok) begin
                model_push(d);
                cnt++;
            end
        end
        idle();
        chk("t5_accepts", W'(cnt), W'(4));
        chk("t5_ready_low", bus.o_ready, 1'b0);
        rdy_mode = 1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            idle();
            ok = bus.o_ready;
        end
        chk("t5_ready_back", ok, 1'b1);
        repeat (3) idle();
        chk("t5_drained", W'(expq.size()), '0);

        // 6: rejected config mid-word, then reset during FLUSH
        push(rand_vec(16'h00AA), 1'b0);
        idle();
        @(negedge clk);
        i_load_cfg = 1'b1;
        i_p        = 4'd3;
        @(negedge clk);
        i_load_cfg = 1'b0;
        chk("t6_cfg_err", o_cfg_err, 1'b1);
        idle();
        chk("t6_cfg_err_pulse", o_cfg_err, 1'b0);
        push(rand_vec(16'h00BB), 1'b0);
        idle();
        chk("t6_p_kept", bus.o_data[15:0], 16'hBBAA);
        rdy_mode = 0;
        push(rand_vec(16'h00CC), 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_flush     = 1'b1;
        idle();
        chk("t6_flush_valid", bus.o_valid, 1'b1);
        reset_dut();
        chk("t6_rst_valid", bus.o_valid, 1'b0);
        chk("t6_rst_ready", bus.o_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_data  = rand_vec(16'($urandom));
            chk("t6_idle_ready", bus.o_ready, 1'b0);
        end
        idle();

        // randomized rounds: random precision, gaps, ready pattern and flush
        rdy_mode = 2;
        for (int r = 0; r < 10; r++) begin
            cfg($urandom_range(1, 16));
            for (int k = 0; k < int'($urandom_range(3, 24)); k++) begin
                if ($urandom_range(0, 3) == 0) idle();
                else push(rand_vec(16'($urandom)), 1'b0);
            end
            do_flush(1'($urandom_range(0, 1)), rand_vec(16'($urandom)));
        end

        repeat (4) idle();
        chk("final_drained", W'(expq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
